frame_min_tracker: RTL and testbench
====================================

# frame_min_tracker

Consumes the stream of registered 8-bit minimum values produced by the upstream compare-and-select stage and reduces each frame of FRAME_LEN samples to a single result: frame minimum, frame maximum, and the index of the first occurrence of the minimum. Input uses a valid/ready handshake. The result is presented on an output valid/ready handshake and held until it is accepted, so downstream logic can apply backpressure.

## Interface
- DW, 8: sample and result data width.
- FRAME_LEN, 16: samples per frame; legal range 2..256.
- IDX_W, 8: index width; must satisfy 2^IDX_W >= FRAME_LEN.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort of the current frame and any held result.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  DW  sample, unsigned.
- out_valid  out  1  result registers hold a complete frame result.
- out_ready  in  1  downstream accepts the result.
- out_min  out  DW  minimum sample of the frame.
- out_max  out  DW  maximum sample of the frame.
- out_idx  out  IDX_W  position (0-based) of the first minimum in the frame.
- frame_cnt  out  8  count of results accepted downstream; wraps 255 -> 0.

## Operation
- Two states: ACCUM and HOLD. Reset state is ACCUM.
- A sample is accepted when in_valid && in_ready. in_ready = (state == ACCUM). It is derived from a registered state only, with no combinational path from out_ready.
- ACCUM, sample accepted with sample counter cnt == 0:
  - run_min = run_max = in_data.
  - run_idx = 0.
- ACCUM, sample accepted with cnt > 0:
  - if in_data < run_min (strict), then run_min = in_data and run_idx = cnt.
  - if in_data > run_max (strict), then run_max = in_data.
  - Ties keep the earlier index.
- After each accepted sample, cnt increments.
- When the accepted sample has cnt == FRAME_LEN-1:
  - the final min, max and idx, including this sample, are loaded into out_min, out_max and out_idx.
  - out_valid is set, cnt returns to 0, and state goes to HOLD.
- HOLD:
  - in_ready = 0.
  - out_min, out_max, out_idx and out_valid are stable.
  - On out_valid && out_ready: out_valid clears, frame_cnt increments, and state goes to ACCUM.
- Comparisons are unsigned, DW bits wide, with no arithmetic growth. cnt is IDX_W bits and never exceeds FRAME_LEN-1.
- clear has priority over all other activity:
  - next cycle: state = ACCUM, cnt = 0, out_valid = 0.
  - run_min/run_max are discarded.
  - out_min, out_max, out_idx and frame_cnt keep their values.
  - A sample presented in the same cycle as clear is not counted, although in_ready may be 1.
- in_valid low while in ACCUM: state holds and no counters advance, so gaps within a frame are allowed.

## Timing
- Reset values:
  - out_valid = 0.
  - out_min = {DW{1'b1}}.
  - out_max = 0.
  - out_idx = 0.
  - frame_cnt = 0.
  - in_ready = 1 (ACCUM), with cnt = 0.
- Latency: out_valid rises on the clock edge that accepts the last sample, so it is visible in the cycle after that sample's handshake.
- Minimum frame period is FRAME_LEN+1 cycles: FRAME_LEN accept cycles plus one HOLD cycle when out_ready is held at 1.
- With out_ready = 1 continuously, out_valid is a 1-cycle pulse per frame.
- Under backpressure, out_valid and the data stay stable until accepted. No sample is accepted in that interval.
- If rst_n is asserted mid-frame or mid-HOLD, all state returns asynchronously to the reset values and the partial frame is lost.
- If clear and out_ready are both asserted in HOLD, clear wins and frame_cnt does not increment.

## Test plan
- Reset then idle (FRAME_LEN=4): out_valid=0, out_min=0xFF, out_max=0x00, in_ready=1, frame_cnt=0.
- FRAME_LEN=4, samples 0x30,0x10,0x50,0x10 back-to-back, out_ready=1:
  - out_valid pulses 1 cycle after the 4th accept.
  - out_min=0x10, out_max=0x50, out_idx=1 (tie keeps the earlier index), frame_cnt goes to 1.
- Backpressure: same frame with out_ready=0 for 5 cycles:
  - in_ready=0 and outputs stable for all 5 cycles.
  - A sample 0x01 offered during HOLD is not accepted.
  - Raising out_ready completes the handshake; next frame starts with cnt=0.
- Gapped input: samples 0xFF,0x00,0x80,0x7F with in_valid low 2 cycles between each -> out_min=0x00, out_max=0xFF, out_idx=1.
- clear after 2 accepted samples (0x05,0x06), then frame 0x40,0x41,0x42,0x43 -> out_min=0x40, out_max=0x43, out_idx=0.
- Stream 256 frames with out_ready=1 -> frame_cnt wraps to 0. Async rst_n mid-frame -> reset values immediately, then the next full frame produces a correct result.

Source files
------------

// File: rtl/frame_min_tracker.sv
// frame_min_tracker: per-frame min/max/first-min-index reduction with valid/ready on both sides
module frame_min_tracker #(
    parameter int DW        = 8,
    parameter int FRAME_LEN = 16,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_min,
    output logic [DW-1:0]    out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic [7:0]       frame_cnt
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d, run_idx_q, run_idx_d, out_idx_q, out_idx_d, nidx;
    logic [DW-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
    logic [DW-1:0] out_min_q, out_min_d, out_max_q, out_max_d, nmin, nmax;
    logic out_valid_q, out_valid_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic accept, first, lt, gt, last;
    assign in_ready  = state_q == ACCUM;
    assign out_valid = out_valid_q;
    assign out_min   = out_min_q;
    assign out_max   = out_max_q;
    assign out_idx   = out_idx_q;
    assign frame_cnt = frame_cnt_q;
    // Fold the incoming sample into the running stats and sequence ACCUM/HOLD; clear overrides all
    always_comb begin
        accept      = in_valid && in_ready;
        first       = cnt_q == '0;
        last        = cnt_q == IDX_W'(FRAME_LEN - 1);
        lt          = in_data < run_min_q;
        gt          = in_data > run_max_q;
        nmin        = (first || lt) ? in_data : run_min_q;
        nmax        = (first || gt) ? in_data : run_max_q;
        nidx        = first ? '0 : (lt ? cnt_q : run_idx_q);
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_min_d   = run_min_q;
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        out_min_d   = out_min_q;
        out_max_d   = out_max_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        frame_cnt_d = frame_cnt_q;
        if (clear) begin
            state_d     = ACCUM;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else if (state_q == ACCUM) begin
            if (accept) begin
                run_min_d = nmin;
                run_max_d = nmax;
                run_idx_d = nidx;
                cnt_d     = last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    out_min_d   = nmin;
                    out_max_d   = nmax;
                    out_idx_d   = nidx;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = ACCUM;
        end
    end
    // State and result registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            run_min_q   <= '0;
            run_max_q   <= '0;
            run_idx_q   <= '0;
            out_min_q   <= '1;
            out_max_q   <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_min_q   <= run_min_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            out_min_q   <= out_min_d;
            out_max_q   <= out_max_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end
endmodule

// File: tb/tb_frame_min_tracker.sv
// tb_frame_min_tracker: directed scenario tests for frame_min_tracker with FRAME_LEN=4
module tb_frame_min_tracker;
    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [7:0] in_data = 8'h00, out_min, out_max, out_idx, frame_cnt;
    int checks = 0, failures = 0;

    frame_min_tracker #(.DW(8), .FRAME_LEN(4), .IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min),
        .out_max(out_max), .out_idx(out_idx), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (out_min !== 8'hFF) begin failures++; $display("FAIL reset_min got=%h want=ff", out_min); end
        checks++; if (out_max !== 8'h00) begin failures++; $display("FAIL reset_max got=%h want=00", out_max); end
        checks++; if (out_idx !== 8'h00) begin failures++; $display("FAIL reset_idx got=%h want=00", out_idx); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_fcnt got=%0d want=0", frame_cnt); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(8'h30); send(8'h10); send(8'h50);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b want=0", out_valid); end
        send(8'h10);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b want=1", out_valid); end
        checks++; if (out_min !== 8'h10) begin failures++; $display("FAIL basic_min got=%h want=10", out_min); end
        checks++; if (out_max !== 8'h50) begin failures++; $display("FAIL basic_max got=%h want=50", out_max); end
        checks++; if (out_idx !== 8'd1) begin failures++; $display("FAIL basic_idx got=%0d want=1", out_idx); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_hold_ready got=%b want=0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%b want=0", out_valid); end
        checks++; if (frame_cnt !== 8'd1) begin failures++; $display("FAIL basic_fcnt got=%0d want=1", frame_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(8'h30); send(8'h10); send(8'h50); send(8'h10);
        in_valid = 1'b1;
        in_data  = 8'h01;
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b want=0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b want=1", i, out_valid); end
            checks++; if ({out_min, out_max, out_idx} !== {8'h10, 8'h50, 8'd1}) begin failures++; $display("FAIL bp_data[%0d] got=%h/%h/%0d want=10/50/1", i, out_min, out_max, out_idx); end
            checks++; if (frame_cnt !== 8'd1) begin failures++; $display("FAIL bp_fcnt[%0d] got=%0d want=1", i, frame_cnt); end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_accept got=%b want=0", out_valid); end
        checks++; if (frame_cnt !== 8'd2) begin failures++; $display("FAIL bp_fcnt got=%0d want=2", frame_cnt); end
        send(8'h20); send(8'h21); send(8'h22); send(8'h23);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_next_valid got=%b want=1", out_valid); end
        checks++; if ({out_min, out_max, out_idx} !== {8'h20, 8'h23, 8'd0}) begin failures++; $display("FAIL bp_next_data got=%h/%h/%0d want=20/23/0", out_min, out_max, out_idx); end
        step();
        checks++; if (frame_cnt !== 8'd3) begin failures++; $display("FAIL bp_next_fcnt got=%0d want=3", frame_cnt); end
    endtask

    task automatic test_gapped();
        logic [7:0] s [4] = '{8'hFF, 8'h00, 8'h80, 8'h7F};
        for (int i = 0; i < 4; i++) begin
            send(s[i]);
            if (i < 3) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gap_early_valid[%0d] got=%b want=0", i, out_valid); end
                step(); step();
            end
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL gap_valid got=%b want=1", out_valid); end
        checks++; if ({out_min, out_max, out_idx} !== {8'h00, 8'hFF, 8'd1}) begin failures++; $display("FAIL gap_data got=%h/%h/%0d want=00/ff/1", out_min, out_max, out_idx); end
        step();
        checks++; if (frame_cnt !== 8'd4) begin failures++; $display("FAIL gap_fcnt got=%0d want=4", frame_cnt); end
    endtask

    task automatic test_clear();
        send(8'h05); send(8'h06);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h01;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++; if ({out_valid, out_min, frame_cnt} !== {1'b0, 8'h00, 8'd4}) begin failures++; $display("FAIL clr_keep got=%b/%h/%0d want=0/00/4", out_valid, out_min, frame_cnt); end
        send(8'h40); send(8'h41); send(8'h42);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_early_valid got=%b want=0", out_valid); end
        send(8'h43);
        checks++; if ({out_valid, out_min, out_max, out_idx} !== {1'b1, 8'h40, 8'h43, 8'd0}) begin failures++; $display("FAIL clr_data got=%b/%h/%h/%0d want=1/40/43/0", out_valid, out_min, out_max, out_idx); end
        step();
        checks++; if (frame_cnt !== 8'd5) begin failures++; $display("FAIL clr_fcnt got=%0d want=5", frame_cnt); end
        out_ready = 1'b0;
        send(8'h09); send(8'h08); send(8'h07); send(8'h08);
        checks++; if ({out_valid, out_min, out_max, out_idx} !== {1'b1, 8'h07, 8'h09, 8'd2}) begin failures++; $display("FAIL clr_hold_data got=%b/%h/%h/%0d want=1/07/09/2", out_valid, out_min, out_max, out_idx); end
        clear     = 1'b1;
        out_ready = 1'b1;
        step();
        clear = 1'b0;
        checks++; if ({out_valid, in_ready, frame_cnt} !== {1'b0, 1'b1, 8'd5}) begin failures++; $display("FAIL clr_hold got=%b/%b/%0d want=0/1/5", out_valid, in_ready, frame_cnt); end
        checks++; if ({out_min, out_max, out_idx} !== {8'h07, 8'h09, 8'd2}) begin failures++; $display("FAIL clr_hold_keep got=%h/%h/%0d want=07/09/2", out_min, out_max, out_idx); end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(8'(i + 3)); send(8'(i)); send(8'(i + 2)); send(8'(i + 1));
            step();
            if (i == 254) begin
                checks++; if (frame_cnt !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d want=255", frame_cnt); end
            end
        end
        checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL wrap_0 got=%0d want=0", frame_cnt); end
        checks++; if ({out_min, out_max, out_idx} !== {8'h00, 8'hFF, 8'd3}) begin failures++; $display("FAIL wrap_last got=%h/%h/%0d want=00/ff/3", out_min, out_max, out_idx); end
    endtask

    task automatic test_async_reset();
        send(8'h33); send(8'h44); send(8'h22); send(8'h55);
        step();
        checks++; if (frame_cnt !== 8'd1) begin failures++; $display("FAIL ar_pre_fcnt got=%0d want=1", frame_cnt); end
        send(8'h11); send(8'h22);
        rst_n = 1'b0;
        #2;
        checks++; if ({out_valid, in_ready, frame_cnt} !== {1'b0, 1'b1, 8'd0}) begin failures++; $display("FAIL ar_ctrl got=%b/%b/%0d want=0/1/0", out_valid, in_ready, frame_cnt); end
        checks++; if ({out_min, out_max, out_idx} !== {8'hFF, 8'h00, 8'd0}) begin failures++; $display("FAIL ar_data got=%h/%h/%0d want=ff/00/0", out_min, out_max, out_idx); end
        rst_n = 1'b1;
        send(8'h60); send(8'h70); send(8'h50);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_early_valid got=%b want=0", out_valid); end
        send(8'h50);
        checks++; if ({out_valid, out_min, out_max, out_idx} !== {1'b1, 8'h50, 8'h70, 8'd2}) begin failures++; $display("FAIL ar_frame got=%b/%h/%h/%0d want=1/50/70/2", out_valid, out_min, out_max, out_idx); end
        step();
        checks++; if (frame_cnt !== 8'd1) begin failures++; $display("FAIL ar_fcnt got=%0d want=1", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gapped();
        test_clear();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
